// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin arbiter sharing one GCD engine among NREQ requesters
module gcd_arbiter #(
    parameter int NBITS   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NBITS-1:0] req_a,
    input  logic [NREQ*NBITS-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NBITS-1:0]      rsp_result,
    output logic                  rsp_err,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NBITS-1:0]      eng_a,
    output logic [NBITS-1:0]      eng_b,
    output logic                  eng_start,
    input  logic                  eng_done,
    input  logic [NBITS-1:0]      eng_result,
    output logic [15:0]           job_count
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [NBITS-1:0]  a_q, a_d;
    logic [NBITS-1:0]  b_q, b_d;
    logic [NBITS-1:0]  result_q, result_d;
    logic              err_q, err_d;
    logic [15:0]       job_count_q, job_count_d;

    logic              grant_found;
    logic [GW-1:0]     grant_idx;
    int                rr_idx;

    // Round-robin search starting just after the last served requester;
    // scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            rr_idx = (int'(last_grant_q) + k) % NREQ;
            if (req_valid[GW'(rr_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(rr_idx);
            end
        end
    end

    // Next-state and datapath for the single job in flight.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        err_d        = err_q;
        job_count_d  = job_count_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    grant_d = grant_idx;
                    a_d     = req_a[int'(grant_idx)*NBITS +: NBITS];
                    b_d     = req_b[int'(grant_idx)*NBITS +: NBITS];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (eng_done) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    state_d  = S_RESPOND;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESPOND;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESPOND: begin
                if (rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    job_count_d  = job_count_q + 16'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any job without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            timer_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            job_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            err_q        <= err_d;
            job_count_q  <= job_count_d;
        end
    end

    // Outputs are state decodes; reset forces the handshake outputs low at once.
    always_comb begin
        req_ready  = (!reset && state_q == S_IDLE && grant_found) ? (NREQ'(1) << grant_idx) : '0;
        rsp_valid  = (!reset && state_q == S_RESPOND) ? (NREQ'(1) << grant_q) : '0;
        rsp_result = reset ? '0 : result_q;
        rsp_err    = !reset && err_q;
        eng_start  = !reset && (state_q == S_ISSUE);
        eng_a      = a_q;
        eng_b      = b_q;
        job_count  = job_count_q;
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - scoreboard bench for gcd_arbiter with a model GCD engine
module tb_gcd_arbiter;

    localparam int NB = 32;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*NB-1:0]  req_a = '0;
    logic [NR*NB-1:0]  req_b = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [NB-1:0]     rsp_result;
    logic              rsp_err;
    logic [NR-1:0]     rsp_ready = '1;
    logic [NB-1:0]     eng_a, eng_b;
    logic              eng_start;
    logic              eng_done;
    logic [NB-1:0]     eng_result = '0;
    logic [15:0]       job_count;

    logic              eng_done_m = 1'b0;
    logic              man_done = 1'b0;
    int                eng_lat = 5;
    int                eng_cnt = -1;
    logic              eng_never = 1'b0;
    logic              eng_force = 1'b0;
    logic [NB-1:0]     force_val = '0;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } rsp_t;

    rsp_t exp_rsp[$];
    int   exp_grant[$];
    int   total = 0;
    int   bad = 0;

    assign eng_done = eng_done_m | man_done;

    always #5 clk = ~clk;

    gcd_arbiter #(.NBITS(NB), .NREQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
        .eng_done(eng_done), .eng_result(eng_result), .job_count(job_count)
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] gcd(logic [31:0] a, logic [31:0] b);
        logic [31:0] t;
        for (int i = 0; i < 64 && b != 0; i++) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Model engine: done pulse eng_lat cycles after it sees eng_start.
    always @(negedge clk) begin
        eng_done_m = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done_m = 1'b1;
                eng_result = eng_force ? force_val : gcd(eng_a, eng_b);
                eng_cnt    = -1;
            end
        end else if (eng_start && !eng_never) begin
            eng_cnt = eng_lat;
        end
    end

    // Monitor: compares grants and accepted responses against the queues.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            if (exp_grant.size() == 0) chk("unexpected_grant", req_ready, 0);
            else chk("grant", req_ready, 64'(1) << exp_grant.pop_front());
        end
        if ((rsp_valid & rsp_ready) != '0) begin
            if (exp_rsp.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
            else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_valid", rsp_valid, 64'(1) << e.idx);
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*NB +: NB] = a;
        req_b[i*NB +: NB] = b;
    endtask

    task automatic push_rsp(input int i, input logic [31:0] r, input logic e);
        rsp_t x;
        x.idx = i;
        x.res = r;
        x.err = e;
        exp_rsp.push_back(x);
    endtask

    task automatic wait_grant(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(req_ready != '0), 1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(nm, exp_rsp.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_job_count", job_count, 0);

        // Single job 48,18 -> 6
        @(posedge clk); #1;
        reset = 1'b0;
        eng_lat = 5;
        exp_grant.push_back(0);
        push_rsp(0, 6, 1'b0);
        set_req(0, 48, 18);
        req_valid = 4'b0001;
        wait_grant("single_grant_seen");
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_eng_start", eng_start, 1);
        chk("single_eng_a", eng_a, 48);
        chk("single_eng_b", eng_b, 18);
        drain("single_drain");
        chk("single_job_count", job_count, 1);

        // Contention from reset: grants 0,1,2,3,0
        @(posedge clk); #1;
        reset = 1'b1;
        eng_lat = 3;
        set_req(0, 12, 8);
        set_req(1, 35, 14);
        set_req(2, 9, 6);
        set_req(3, 81, 27);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) exp_grant.push_back(i % 4);
        push_rsp(0, 4, 1'b0);
        push_rsp(1, 7, 1'b0);
        push_rsp(2, 3, 1'b0);
        push_rsp(3, 27, 1'b0);
        push_rsp(0, 4, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) wait_grant("cont_grant_seen");
        @(posedge clk); #1;
        req_valid = '0;
        drain("cont_drain");
        chk("cont_job_count", job_count, 5);

        // Timeout: engine silent, requester 1
        eng_never = 1'b1;
        exp_grant.push_back(1);
        push_rsp(1, 0, 1'b1);
        set_req(1, 50, 20);
        req_valid = 4'b0010;
        wait_grant("to_grant_seen");
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("to_eng_start", eng_start, 1);
        n = 0;
        while (rsp_valid == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, 17);
        drain("to_drain");
        chk("to_job_count", job_count, 6);
        eng_never = 1'b0;

        // Collision: done and timeout together, forced result 7
        eng_lat = 16;
        eng_force = 1'b1;
        force_val = 7;
        exp_grant.push_back(2);
        push_rsp(2, 7, 1'b0);
        set_req(2, 100, 75);
        req_valid = 4'b0100;
        wait_grant("col_grant_seen");
        @(posedge clk); #1;
        req_valid = '0;
        drain("col_drain");
        chk("col_job_count", job_count, 7);
        eng_force = 1'b0;

        // Backpressure on requester 2 while requester 0 waits
        eng_lat = 2;
        rsp_ready = 4'b1011;
        exp_grant.push_back(2);
        exp_grant.push_back(0);
        push_rsp(2, 7, 1'b0);
        push_rsp(0, 5, 1'b0);
        set_req(2, 21, 14);
        set_req(0, 5, 10);
        req_valid = 4'b0100;
        wait_grant("bp_grant_seen");
        @(posedge clk); #1;
        req_valid = 4'b0001;
        n = 0;
        @(negedge clk);
        while (rsp_valid == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 4'b0100);
            chk("bp_rsp_result", rsp_result, 7);
            chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = '1;
        wait_grant("bp_resume_grant");
        @(posedge clk); #1;
        req_valid = '0;
        drain("bp_drain");
        chk("bp_job_count", job_count, 9);

        // Reset mid-WAIT, then a late eng_done
        eng_never = 1'b1;
        exp_grant.push_back(3);
        set_req(3, 40, 30);
        req_valid = 4'b1000;
        wait_grant("rw_grant_seen");
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rw_rst_rsp_valid", rsp_valid, 0);
        chk("rw_rst_eng_start", eng_start, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rw_no_rsp", rsp_valid, 0);
        end
        chk("rw_job_count", job_count, 0);
        eng_never = 1'b0;
        eng_lat = 2;
        exp_grant.push_back(0);
        push_rsp(0, 6, 1'b0);
        set_req(0, 18, 12);
        set_req(3, 7, 7);
        @(posedge clk); #1;
        req_valid = 4'b1001;
        wait_grant("rw_next_grant");
        @(posedge clk); #1;
        req_valid = '0;
        drain("rw_drain");
        chk("rw_job_count_after", job_count, 1);

        repeat (3) @(posedge clk);
        chk("grant_queue_empty", exp_grant.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
